// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory bus between instruction-fetch and data ports.
// Latency: request to m_req 1 cycle, m_ack to i_ack/d_ack 1 cycle (2 cycles minimum end to end).
// Backpressure: m_req and its payload are held until m_ack or wait-count timeout; one transaction in flight.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    localparam logic       LG_I     = 1'b0;
    localparam logic       LG_D     = 1'b1;
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_t     state;
    logic       last_grant;
    logic [7:0] wait_cnt;
    logic       aborted;

    logic       cur_req;
    logic       abort_now;
    logic [7:0] cnt_nxt;
    logic       timeout_hit;
    logic       grant_d;
    logic       grant_i;

    // Arbitration and completion decode; dropping req in the m_ack cycle itself is not an abort
    always_comb begin
        cur_req     = (state == GNT_D) ? d_req : i_req;
        abort_now   = aborted | (~cur_req & ~m_ack);
        cnt_nxt     = wait_cnt + 8'd1;
        timeout_hit = (TO_LIMIT != 8'd0) && (cnt_nxt == TO_LIMIT);
        grant_d     = d_req & (~i_req | (last_grant == LG_I));
        grant_i     = i_req & ~grant_d;
    end

    // Grant FSM with registered bus payload, read data and completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= LG_I;
            wait_cnt   <= 8'd0;
            aborted    <= 1'b0;
            i_rdata    <= 32'd0;
            i_ack      <= 1'b0;
            d_rdata    <= 32'd0;
            d_ack      <= 1'b0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= 32'd0;
            m_wdata    <= 32'd0;
            m_wstrb    <= 4'd0;
            bus_err    <= 1'b0;
        end else begin
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    aborted  <= 1'b0;
                    if (grant_d) begin
                        state      <= GNT_D;
                        last_grant <= LG_D;
                        m_req      <= 1'b1;
                        m_we       <= d_we;
                        m_addr     <= d_addr;
                        m_wdata    <= d_wdata;
                        m_wstrb    <= d_wstrb;
                    end else if (grant_i) begin
                        state      <= GNT_I;
                        last_grant <= LG_I;
                        m_req      <= 1'b1;
                        m_we       <= 1'b0;
                        m_addr     <= i_addr;
                        m_wdata    <= 32'd0;
                        m_wstrb    <= 4'd0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (m_ack || timeout_hit) begin
                        state   <= IDLE;
                        m_req   <= 1'b0;
                        bus_err <= ~m_ack;
                        if (!abort_now) begin
                            if (state == GNT_D) begin
                                d_ack   <= 1'b1;
                                d_rdata <= m_ack ? m_rdata : 32'd0;
                            end else begin
                                i_ack   <= 1'b1;
                                i_rdata <= m_ack ? m_rdata : 32'd0;
                            end
                        end
                    end else begin
                        wait_cnt <= cnt_nxt;
                        aborted  <= abort_now;
                    end
                end
                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cycle checks plus a response scoreboard for mem_arbiter with TIMEOUT=4.
// Latency: n/a (bench).
// Backpressure: bench plays the memory and stalls m_ack as each scenario requires.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        bus_err;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ack(m_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called in the first m_req cycle of a granted transaction; ends at the negedge of the ack-pulse cycle.
    task automatic serve(input bit is_d, input int stall, input logic [31:0] rdata,
                         input logic [31:0] ea, input bit ewe, input logic [31:0] ewd,
                         input logic [3:0] ews, input bit keep);
        exp_t e;
        for (int s = 0; s <= stall; s++) begin
            m_ack = (s == stall);
            if (s == stall) begin
                m_rdata = rdata;
                e.is_d  = is_d;
                e.rdata = rdata;
                e.err   = 1'b0;
                exp_q.push_back(e);
            end
            @(negedge clk);
            chk("m_req_hold", 32'(m_req), 32'd1);
            chk("m_addr", m_addr, ea);
            chk("m_we", 32'(m_we), 32'(ewe));
            chk("m_wdata", m_wdata, ewd);
            chk("m_wstrb", 32'(m_wstrb), 32'(ews));
            tick;
        end
        m_ack   = 1'b0;
        m_rdata = $urandom;
        if (!keep) begin
            if (is_d) d_req = 1'b0;
            else      i_req = 1'b0;
        end
        @(negedge clk);
        chk("m_req_drop", 32'(m_req), 32'd0);
        chk("ack_pulse", 32'(is_d ? d_ack : i_ack), 32'd1);
    endtask

    // Scoreboard: every ack or bus_err must match the oldest expected response
    always @(negedge clk) begin
        if (!rst && (i_ack || d_ack || bus_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'({i_ack, d_ack, bus_err}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_src", 32'(d_ack), 32'(mon_e.is_d));
                chk("resp_rdata", mon_e.is_d ? d_rdata : i_rdata, mon_e.rdata);
                chk("resp_err", 32'(bus_err), 32'(mon_e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] last_i;
        exp_t e;
        rst = 1'b1; i_req = 1'b0; i_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0; m_rdata = 32'd0; m_ack = 1'b0;
        tick; tick;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_acks", 32'({i_ack, d_ack, bus_err}), 32'd0);

        // Tie after reset: data first, then instruction, then the re-tie goes to data
        tick;
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        tick;
        serve(1'b1, 0, 32'h11111111, 32'h2000, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0);
        tick;
        serve(1'b0, 0, 32'h22222222, 32'h40, 1'b0, 32'd0, 4'd0, 1'b0);
        tick;
        i_req = 1'b1; i_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004; d_wdata = 32'h55AA55AA; d_wstrb = 4'h3;
        tick;
        serve(1'b1, 1, 32'h33333333, 32'h2004, 1'b0, 32'h55AA55AA, 4'h3, 1'b0);
        tick;
        serve(1'b0, 0, 32'h44444444, 32'h44, 1'b0, 32'd0, 4'd0, 1'b0);

        // Zero-wait fetch: m_addr at N+1, i_ack and i_rdata at N+2
        tick;
        i_req = 1'b1; i_addr = 32'h100;
        tick;
        serve(1'b0, 0, 32'h00000013, 32'h100, 1'b0, 32'd0, 4'd0, 1'b0);
        chk("fetch_rdata", i_rdata, 32'h13);

        // Back-to-back fetches: req held in the ack cycle is regranted at once
        tick;
        i_req = 1'b1; i_addr = 32'h200;
        tick;
        serve(1'b0, 0, 32'hA0000001, 32'h200, 1'b0, 32'd0, 4'd0, 1'b1);
        i_addr = 32'h204;
        tick;
        serve(1'b0, 0, 32'hA0000002, 32'h204, 1'b0, 32'd0, 4'd0, 1'b0);
        last_i = 32'hA0000002;

        // Stalled load: ack arrives as the wait counter reaches TIMEOUT, ack must win
        tick;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3100; d_wdata = 32'h0; d_wstrb = 4'h0;
        tick;
        serve(1'b1, 3, 32'h12345678, 32'h3100, 1'b0, 32'h0, 4'h0, 1'b0);
        tick;
        chk("d_ack_single", 32'(d_ack), 32'd0);
        chk("d_rdata_hold", d_rdata, 32'h12345678);

        // Aborted fetch: no i_ack, i_rdata unchanged, pending d_req granted next
        i_req = 1'b1; i_addr = 32'h300;
        tick;
        i_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_wdata = 32'h0; d_wstrb = 4'h0;
        @(negedge clk);
        chk("abort_m_req", 32'(m_req), 32'd1);
        tick;
        @(negedge clk);
        chk("abort_wait_m_req", 32'(m_req), 32'd1);
        tick;
        m_ack = 1'b1; m_rdata = 32'hBAD0BAD0;
        tick;
        m_ack = 1'b0;
        @(negedge clk);
        chk("abort_no_ack", 32'(i_ack), 32'd0);
        chk("abort_rdata", i_rdata, last_i);
        chk("abort_m_req_drop", 32'(m_req), 32'd0);
        tick;
        serve(1'b1, 0, 32'h0A0A0A0A, 32'h3000, 1'b0, 32'h0, 4'h0, 1'b0);

        // Timeout: m_req high 4 cycles, then bus_err with i_ack and i_rdata=0
        tick;
        i_req = 1'b1; i_addr = 32'h500;
        tick;
        e.is_d = 1'b0; e.rdata = 32'd0; e.err = 1'b1;
        exp_q.push_back(e);
        for (int c = 0; c < 4; c++) begin
            m_ack = 1'b0;
            @(negedge clk);
            chk("to_m_req", 32'(m_req), 32'd1);
            chk("to_no_err", 32'(bus_err), 32'd0);
            tick;
        end
        i_req = 1'b0;
        @(negedge clk);
        chk("to_m_req_drop", 32'(m_req), 32'd0);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_i_ack", 32'(i_ack), 32'd1);
        chk("to_i_rdata", i_rdata, 32'd0);

        // Reset mid-transaction: m_req drops, late m_ack ignored, rdata cleared
        tick;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4000; d_wdata = 32'h01020304; d_wstrb = 4'h1;
        tick;
        @(negedge clk);
        chk("rst_mid_m_req", 32'(m_req), 32'd1);
        tick;
        rst = 1'b1; d_req = 1'b0;
        tick;
        rst = 1'b0; m_ack = 1'b1; m_rdata = 32'hFEEDFACE;
        @(negedge clk);
        chk("rst_mid_drop", 32'(m_req), 32'd0);
        chk("rst_mid_d_rdata", d_rdata, 32'd0);
        tick;
        m_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_ignored", 32'({d_ack, i_ack, bus_err, m_req}), 32'd0);
        tick; tick;

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
